// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Ports: CPU c_*, memory m_*, DMA BR/BG + dma_* snoop, num_access/num_hit.
module data_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 c_readM,
  input  logic                 c_writeM,
  input  logic [WORD_SIZE-1:0] c_address,
  inout  wire  [WORD_SIZE-1:0] c_data,
  output logic                 c_doneM,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  inout  wire  [WORD_SIZE-1:0] m_data,
  input  logic                 m_doneM,
  input  logic                 BR,
  output logic                 BG,
  input  logic                 dma_wr,
  input  logic [WORD_SIZE-1:0] dma_address,
  output logic [WORD_SIZE-1:0] num_access,
  output logic [WORD_SIZE-1:0] num_hit
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TLO   = OFF_W + IDX_W;
  localparam int TAG_W = WORD_SIZE - TLO;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_DONE, S_GRANT
  } state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [WORD_SIZE-1:0] line_q [NUM_LINES][LINE_WORDS];
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [OFF_W-1:0]     k_q;
  logic                 rd_q;
  logic                 done_q;
  logic                 kill_q;

  logic [IDX_W-1:0]     c_idx, a_idx, s_idx, r_idx;
  logic [TAG_W-1:0]     c_tag, a_tag, s_tag;
  logic [OFF_W-1:0]     r_off;
  logic [WORD_SIZE-1:0] r_addr, r_word;
  logic                 hit, a_hit;
  logic                 snoop_hit, snoop_fill;
  logic                 unused_ok;

  assign c_idx = c_address[TLO-1:OFF_W];
  assign c_tag = c_address[WORD_SIZE-1:TLO];
  assign a_idx = addr_q[TLO-1:OFF_W];
  assign a_tag = addr_q[WORD_SIZE-1:TLO];
  assign s_idx = dma_address[TLO-1:OFF_W];
  assign s_tag = dma_address[WORD_SIZE-1:TLO];
  assign unused_ok = ^dma_address[OFF_W-1:0];

  assign hit = (state == S_IDLE) & c_readM & ~c_writeM
             & valid_q[c_idx] & (tag_q[c_idx] == c_tag);
  assign a_hit = valid_q[a_idx] & (tag_q[a_idx] == a_tag);
  assign snoop_hit = dma_wr & valid_q[s_idx]
                   & (tag_q[s_idx] == s_tag);
  // DMA write into the line being refilled: the refill must not
  // leave it valid, since the fetched words may be stale.
  assign snoop_fill = dma_wr & (state == S_FILL)
    & (dma_address[WORD_SIZE-1:OFF_W] == addr_q[WORD_SIZE-1:OFF_W]);

  assign r_addr = done_q ? addr_q : c_address;
  assign r_idx  = r_addr[TLO-1:OFF_W];
  assign r_off  = r_addr[OFF_W-1:0];
  assign r_word = line_q[r_idx][r_off];

  assign c_doneM = done_q | hit;
  assign c_data = (hit | (done_q & rd_q)) ? r_word
                : {WORD_SIZE{1'bz}};
  assign m_address = BG ? {WORD_SIZE{1'bz}}
    : (m_writeM ? addr_q : {addr_q[WORD_SIZE-1:OFF_W], k_q});
  assign m_data = m_writeM ? wdata_q : {WORD_SIZE{1'bz}};

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      m_readM    <= 1'b0;
      m_writeM   <= 1'b0;
      BG         <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      kill_q     <= 1'b0;
      k_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      num_access <= '0;
      num_hit    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            num_access <= num_access + WORD_SIZE'(1);
            num_hit    <= num_hit + WORD_SIZE'(1);
          end else if (BR) begin
            state <= S_GRANT;
            BG    <= 1'b1;
          end else if (c_writeM) begin
            state    <= S_WRITE;
            m_writeM <= 1'b1;
            addr_q   <= c_address;
            wdata_q  <= c_data;
            rd_q     <= 1'b0;
          end else if (c_readM) begin
            state          <= S_FILL;
            m_readM        <= 1'b1;
            addr_q         <= c_address;
            rd_q           <= 1'b1;
            k_q            <= '0;
            kill_q         <= 1'b0;
            valid_q[c_idx] <= 1'b0;
          end
        end
        S_FILL: begin
          if (snoop_fill) kill_q <= 1'b1;
          if (m_doneM) begin
            line_q[a_idx][k_q] <= m_data;
            k_q <= k_q + OFF_W'(1);
            if (k_q == LAST) begin
              m_readM        <= 1'b0;
              tag_q[a_idx]   <= a_tag;
              valid_q[a_idx] <= ~(kill_q | snoop_fill);
              done_q         <= 1'b1;
              state          <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (m_doneM) begin
            if (a_hit) line_q[a_idx][addr_q[OFF_W-1:0]] <= wdata_q;
            m_writeM <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          num_access <= num_access + WORD_SIZE'(1);
          state      <= S_IDLE;
        end
        S_GRANT: begin
          if (!BR) begin
            BG    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (snoop_hit) valid_q[s_idx] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed + random checks of data_cache against a
// line-map / flat-memory reference model and a latency-LAT memory.
module tb_data_cache;
  localparam int LAT      = 3;
  localparam int FILL_CYC = 4 * LAT + 1;
  localparam int WR_CYC   = LAT + 1;
  localparam int TMO      = 200;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        c_readM = 1'b0;
  logic        c_writeM = 1'b0;
  logic [15:0] c_address = '0;
  logic        cpu_drv = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic        m_doneM = 1'b0;
  logic        BR = 1'b0;
  logic        dma_wr = 1'b0;
  logic [15:0] dma_address = '0;
  logic [15:0] dma_wdata = '0;
  wire  [15:0] c_data;
  wire  [15:0] m_data;
  wire  [15:0] m_address;
  logic        c_doneM, m_readM, m_writeM, BG;
  logic [15:0] num_access, num_hit;

  bit   [15:0] mem [65536];
  bit          written [65536];
  logic [15:0] rdat = '0;
  int          lcnt = 0;
  logic [15:0] rd_a[$];
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];

  int tests = 0;
  int fails = 0;
  int acc = 0;
  int hits = 0;
  logic [15:0] ref_mem [int];
  logic [13:0] line_of [int];

  assign c_data = cpu_drv ? cpu_wdata : 'z;
  assign m_data = (m_readM && !m_writeM) ? rdat : 'z;

  data_cache dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .c_readM(c_readM), .c_writeM(c_writeM),
    .c_address(c_address), .c_data(c_data), .c_doneM(c_doneM),
    .m_readM(m_readM), .m_writeM(m_writeM),
    .m_address(m_address), .m_data(m_data), .m_doneM(m_doneM),
    .BR(BR), .BG(BG), .dma_wr(dma_wr), .dma_address(dma_address),
    .num_access(num_access), .num_hit(num_hit)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return written[a] ? mem[a] : init_val(a);
  endfunction

  // Main memory: m_doneM pulses on every LAT-th strobed cycle.
  always @(posedge Clk) begin
    if (dma_wr) begin
      mem[dma_address] <= dma_wdata;
      written[dma_address] <= 1'b1;
    end
    if (m_writeM && m_doneM) begin
      mem[m_address] <= m_data;
      written[m_address] <= 1'b1;
      wr_a.push_back(m_address);
      wr_d.push_back(m_data);
    end
    if (m_readM && m_doneM) rd_a.push_back(m_address);
    if (!(m_readM || m_writeM)) begin
      lcnt <= 0;
      m_doneM <= 1'b0;
    end else begin
      m_doneM <= (lcnt == LAT - 2);
      if (lcnt == LAT - 2) rdat <= mem_rd(m_address);
      lcnt <= (lcnt == LAT - 1) ? 0 : lcnt + 1;
    end
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic bit cached(input logic [15:0] a);
    int idx = int'(a[3:2]);
    return line_of.exists(idx) && line_of[idx] == a[15:2];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [15:0] a, output logic [15:0] d);
    bit h;
    int cyc;
    h = cached(a);
    @(negedge Clk);
    c_address = a;
    c_readM = 1'b1;
    #1;
    cyc = 0;
    while (!c_doneM && cyc < TMO) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    d = c_data;
    chk("rd_timeout", 16'(cyc < TMO), 16'd1);
    chk("rd_data", d, ref_rd(a));
    chk("rd_latency", 16'(cyc), h ? 16'd0 : 16'(FILL_CYC));
    @(posedge Clk);
    #1;
    c_readM = 1'b0;
    acc++;
    if (h) hits++;
    else line_of[int'(a[3:2])] = a[15:2];
    chk("num_access", num_access, 16'(acc));
    chk("num_hit", num_hit, 16'(hits));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] v);
    int cyc;
    int base;
    base = wr_a.size();
    @(negedge Clk);
    c_address = a;
    cpu_wdata = v;
    cpu_drv = 1'b1;
    c_writeM = 1'b1;
    #1;
    cyc = 0;
    while (!c_doneM && cyc < TMO) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    chk("wr_latency", 16'(cyc), 16'(WR_CYC));
    @(posedge Clk);
    #1;
    c_writeM = 1'b0;
    cpu_drv = 1'b0;
    acc++;
    ref_mem[int'(a)] = v;
    chk("wr_bus_count", 16'(wr_a.size() - base), 16'd1);
    if (wr_a.size() > base) begin
      chk("wr_bus_addr", wr_a[base], a);
      chk("wr_bus_data", wr_d[base], v);
    end
    chk("num_access", num_access, 16'(acc));
  endtask

  task automatic do_dma(input logic [15:0] a, input logic [15:0] v);
    int cyc;
    @(negedge Clk);
    BR = 1'b1;
    cyc = 0;
    while (!BG && cyc < TMO) begin
      @(negedge Clk);
      cyc++;
    end
    chk("bg_up", 16'(BG), 16'd1);
    chk("grant_no_read", 16'(m_readM | m_writeM), 16'd0);
    dma_address = a;
    dma_wdata = v;
    dma_wr = 1'b1;
    @(negedge Clk);
    dma_wr = 1'b0;
    BR = 1'b0;
    ref_mem[int'(a)] = v;
    if (cached(a)) line_of.delete(int'(a[3:2]));
    cyc = 0;
    while (BG && cyc < TMO) begin
      @(negedge Clk);
      cyc++;
    end
    chk("bg_down", 16'(BG), 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] a;
    logic [15:0] v;
    int cyc;
    int base;
    int op;
    bit bg_seen;

    repeat (3) @(negedge Clk);
    chk("rst_m_readM", 16'(m_readM), 16'd0);
    chk("rst_m_writeM", 16'(m_writeM), 16'd0);
    chk("rst_BG", 16'(BG), 16'd0);
    chk("rst_c_doneM", 16'(c_doneM), 16'd0);
    chk("rst_num_access", num_access, 16'd0);
    chk("rst_num_hit", num_hit, 16'd0);
    Reset_N = 1'b1;

    base = rd_a.size();
    do_read(16'h0013, d);
    chk("fill_words", 16'(rd_a.size() - base), 16'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < rd_a.size())
        chk("fill_addr", rd_a[base + i], 16'(16'h0010 + i));
    do_read(16'h0011, d);
    chk("plan_hits", num_hit, 16'd1);
    chk("plan_access", num_access, 16'd2);

    do_write(16'h0012, 16'hBEEF);
    do_read(16'h0012, d);
    chk("write_hit_data", d, 16'hBEEF);
    do_write(16'h0100, 16'h1234);
    do_read(16'h0100, d);

    do_read(16'h0050, d);
    do_read(16'h0010, d);
    do_read(16'h0044, d);

    @(negedge Clk);
    c_address = 16'h0020;
    c_readM = 1'b1;
    #1;
    cyc = 0;
    bg_seen = 1'b0;
    while (!c_doneM && cyc < TMO) begin
      @(negedge Clk);
      #1;
      cyc++;
      if (cyc == 4) BR = 1'b1;
      bg_seen |= BG;
    end
    chk("br_fill_data", c_data, ref_rd(16'h0020));
    chk("br_fill_latency", 16'(cyc), 16'(FILL_CYC));
    chk("bg_during_fill", 16'(bg_seen), 16'd0);
    @(posedge Clk);
    #1;
    c_readM = 1'b0;
    acc++;
    line_of[0] = 14'h0008;
    chk("num_access", num_access, 16'(acc));
    cyc = 0;
    while (!BG && cyc < 5) begin
      @(negedge Clk);
      cyc++;
    end
    chk("bg_after_done", 16'(BG), 16'd1);

    @(negedge Clk);
    c_address = 16'h0045;
    c_readM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hit_held_off", 16'(c_doneM), 16'd0);
      @(negedge Clk);
    end
    dma_address = 16'h0021;
    dma_wdata = 16'hCAFE;
    dma_wr = 1'b1;
    @(negedge Clk);
    dma_wr = 1'b0;
    BR = 1'b0;
    ref_mem[16'h0021] = 16'hCAFE;
    line_of.delete(0);
    #1;
    cyc = 0;
    while (!c_doneM && cyc < TMO) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    chk("held_hit_cycles", 16'(cyc), 16'd1);
    chk("held_hit_data", c_data, ref_rd(16'h0045));
    @(posedge Clk);
    #1;
    c_readM = 1'b0;
    acc++;
    hits++;
    chk("num_hit", num_hit, 16'(hits));
    do_read(16'h0021, d);
    chk("dma_refetch", d, 16'hCAFE);

    @(negedge Clk);
    c_address = 16'h0080;
    c_readM = 1'b1;
    repeat (5) @(negedge Clk);
    chk("pre_reset_m_readM", 16'(m_readM), 16'd1);
    Reset_N = 1'b0;
    @(posedge Clk);
    #1;
    chk("mid_rst_m_readM", 16'(m_readM), 16'd0);
    chk("mid_rst_access", num_access, 16'd0);
    chk("mid_rst_hit", num_hit, 16'd0);
    c_readM = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    line_of.delete();
    acc = 0;
    hits = 0;
    do_read(16'h0045, d);

    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 95));
      v = 16'($urandom);
      if (op < 6) do_read(a, d);
      else if (op < 9) do_write(a, v);
      else do_dma(a, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's data-memory port (c_readM/c_writeM/c_address/c_data/c_doneM) and word-wide main memory.
- Hides multi-cycle memory latency on read hits. Serialises misses and writes.
- Grants the memory bus to the DMA engine via BR/BG when idle.
- Invalidates lines that DMA writes.

Parameters:
- WORD_SIZE, 16, data/address width in bits.
- LINE_WORDS, 4, words per line (power of 2). OFF_W = log2(LINE_WORDS).
- NUM_LINES, 4, number of lines (power of 2). IDX_W = log2(NUM_LINES).

Ports:
- Clk  input  1  clock.
- Reset_N  input  1  reset: synchronous, active-low.
- c_readM  input  1  CPU read request; held until c_doneM.
- c_writeM  input  1  CPU write request; held until c_doneM.
- c_address  input  WORD_SIZE  CPU word address.
- c_data  inout  WORD_SIZE  driven by the CPU on writes; driven by the cache on reads while c_doneM=1; Z otherwise.
- c_doneM  output  1  access complete this cycle.
- m_readM  output  1  memory read strobe.
- m_writeM  output  1  memory write strobe.
- m_address  output  WORD_SIZE  memory word address; Z while BG=1.
- m_data  inout  WORD_SIZE  driven by the cache only while m_writeM=1.
- m_doneM  input  1  memory completed the current word; 1-cycle pulse.
- BR  input  1  DMA bus request.
- BG  output  1  bus grant to DMA.
- dma_wr  input  1  DMA writing memory this cycle (snoop).
- dma_address  input  WORD_SIZE  DMA write address (snoop).
- num_access  output  WORD_SIZE  completed CPU accesses.
- num_hit  output  WORD_SIZE  read hits.

Behaviour:
- Address split: offset = addr[OFF_W-1:0]; index = addr[OFF_W+IDX_W-1:OFF_W]; tag = remaining upper bits.
- Per line storage: valid bit, tag, LINE_WORDS data words.
- Reset values: all valid=0; state IDLE; m_readM=0; m_writeM=0; BG=0; counters=0.
- Output c_doneM is 0 out of reset, except for the combinational read-hit case below.
- States:
  - IDLE: no memory operation in progress.
  - FILL: line refill, word counter k = 0..LINE_WORDS-1.
  - WRITE: write-through of one word.
  - DONE: one-cycle completion of a miss or write.
  - GRANT: bus handed to DMA.
- IDLE, read hit (valid and tag match):
  - c_doneM=1 combinationally in the same cycle; c_data = line word[offset].
  - State stays IDLE; num_access++ and num_hit++ at the edge.
  - Zero-wait hits are served in IDLE only; a read hit is not served while BG=1.
- IDLE, read miss, BR=0 -> FILL, k=0.
  - In FILL: m_readM=1; m_address = {tag, index, k}.
  - On m_doneM: store m_data into word k, k++.
  - After word LINE_WORDS-1: set valid, write tag -> DONE.
  - Refill order is always word 0 upward, not critical-word-first.
- IDLE, write, BR=0 -> WRITE.
  - m_writeM=1; m_address=c_address; m_data=c_data.
  - On m_doneM: if hit, update the cached word; a miss allocates nothing -> DONE.
- DONE:
  - c_doneM=1 registered; for a read, c_data = line word[offset]. Then -> IDLE.
  - num_access++. A read whose tag was refilled is not counted as a hit.
  - The CPU must drop or change its request at the edge ending DONE. A request still present in IDLE is treated as new.
- Bus arbitration:
  - In IDLE with BR=1 and no read hit pending: -> GRANT, BG=1. BR has priority over a pending miss or write.
  - In GRANT: cache drives no m_* signals; a CPU miss or write waits.
  - BR falls -> BG=0 next cycle -> IDLE.
  - BR is never honoured mid-FILL or mid-WRITE; it waits for IDLE.
- Snoop: dma_wr=1 whose dma_address index/tag matches a valid line clears that valid bit at the edge, in any state.
  - If the snoop hits the line currently being filled, the fill completes but valid stays 0.
- Reset mid-operation: Reset_N=0 at any edge returns the block to reset values; strobes drop on the next cycle.
- Counters wrap modulo 2^WORD_SIZE.
- c_readM and c_writeM asserted together is illegal; write takes precedence.

Test Plan:
- Read 0x0013 on cold cache, mem latency 3 cycles/word -> four m_readM words 0x0010..0x0013; c_doneM after 12+1 cycles with mem[0x13]. Re-read 0x0011 -> c_doneM same cycle, num_hit=1, num_access=2.
- Write 0x0012=0xBEEF after the fill -> m_writeM with address 0x12 and data 0xBEEF. Read 0x0012 -> hit returns 0xBEEF. Write miss 0x0100 -> no allocation; later read 0x0100 misses.
- Conflict: fill 0x0010, then read 0x0050 (same index, new tag) -> refill. Read 0x0010 -> miss again.
- BR=1 during FILL -> BG stays 0 until DONE→IDLE, then BG=1. While BG=1, a CPU read hit is held off and only completes after BR drops.
- dma_wr to 0x0011 while line 0x0010 is valid -> next read 0x0011 misses and refetches the DMA-written value.
- Reset_N=0 mid-FILL -> m_readM=0 next cycle; all lines invalid; counters 0.
